// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder datapath: FSM encodings and width helpers.
package serial_pkg;

  typedef logic [1:0] ser_state_t;

  localparam ser_state_t ST_IDLE  = 2'd0;
  localparam ser_state_t ST_CLEAR = 2'd1;
  localparam ser_state_t ST_SHIFT = 2'd2;

  localparam int unsigned SER_WIDTH = 8;

  // Bit counter width for a word of w bits; never narrower than one bit.
  function automatic int unsigned ser_cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_shift_pair.sv
// Dual parallel-in/serial-out shift register, LSB first with zero fill.
// Load takes priority over shift.
module serial_shift_pair
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             a_lsb_o,
  output logic             b_lsb_o
);

  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;

  always_comb begin
    sa_d = sa_q;
    sb_d = sb_q;
    if (load_i) begin
      sa_d = a_i;
      sb_d = b_i;
    end else if (shift_i) begin
      sa_d = sa_q >> 1;
      sb_d = sb_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q <= '0;
      sb_q <= '0;
    end else begin
      sa_q <= sa_d;
      sb_q <= sb_d;
    end
  end

  assign a_lsb_o = sa_q[0];
  assign b_lsb_o = sb_q[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Accepts operand pairs and streams them LSB-first to a bit-serial adder, issuing a carry
// clear before every word. All outputs except in_ready are registered.
module serial_operand_feeder
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             a_bit,
  output logic             b_bit,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             adder_clr,
  output logic             busy
);

  localparam int unsigned    CntW    = ser_cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  ser_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic a_bit_q, a_bit_d;
  logic b_bit_q, b_bit_d;
  logic bit_valid_q, bit_valid_d;
  logic first_bit_q, first_bit_d;
  logic last_bit_q, last_bit_d;
  logic adder_clr_q, adder_clr_d;
  logic busy_q, busy_d;

  logic accept;
  logic at_last;
  logic shift_en;
  logic a_lsb, b_lsb;

  assign at_last  = (state_q == ST_SHIFT) && (cnt_q == CntLast);
  assign in_ready = (state_q == ST_IDLE) || at_last;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
      end
      ST_SHIFT: begin
        if (cnt_q == CntLast) begin
          state_d = accept ? ST_CLEAR : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The register presents bit k while the shift pair already holds bit k+1 at its LSB.
  assign shift_en = (state_d == ST_SHIFT);

  serial_shift_pair #(
    .WIDTH(WIDTH)
  ) u_shift_pair (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .shift_i(shift_en),
    .a_i    (in_a),
    .b_i    (in_b),
    .a_lsb_o(a_lsb),
    .b_lsb_o(b_lsb)
  );

  always_comb begin
    bit_valid_d = (state_d == ST_SHIFT);
    a_bit_d     = bit_valid_d && a_lsb;
    b_bit_d     = bit_valid_d && b_lsb;
    first_bit_d = bit_valid_d && (cnt_d == '0);
    last_bit_d  = bit_valid_d && (cnt_d == CntLast);
    adder_clr_d = (state_d == ST_CLEAR);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_bit_q     <= 1'b0;
      b_bit_q     <= 1'b0;
      bit_valid_q <= 1'b0;
      first_bit_q <= 1'b0;
      last_bit_q  <= 1'b0;
      adder_clr_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_bit_q     <= a_bit_d;
      b_bit_q     <= b_bit_d;
      bit_valid_q <= bit_valid_d;
      first_bit_q <= first_bit_d;
      last_bit_q  <= last_bit_d;
      adder_clr_q <= adder_clr_d;
      busy_q      <= busy_d;
    end
  end

  assign a_bit     = a_bit_q;
  assign b_bit     = b_bit_q;
  assign bit_valid = bit_valid_q;
  assign first_bit = first_bit_q;
  assign last_bit  = last_bit_q;
  assign adder_clr = adder_clr_q;
  assign busy      = busy_q;

endmodule
